// File: rtl/pipe_hazard_scoreboard.sv
// pipe_hazard_scoreboard: hazard/forwarding scoreboard for a DEPTH-stage
// post-decode pipeline. Stage 1 is the execute-stage consumer; stages
// 2..DEPTH are producers. Each EX source port picks a forwarding source or
// raises a load-use stall, which freezes stage 1 and injects a bubble into
// stage 2.
//
// Optional feature macro: PIPE_HAZARD_SCOREBOARD_FWD_EN
//   defined   : results are forwarded once they reach their ready stage
//   undefined : fwd_sel stays 0 and any in-flight writer match stalls
module pipe_hazard_scoreboard #(
    parameter int DEPTH    = 3,
    parameter int REG_W    = 5,
    parameter int RPORTS   = 2,
    parameter int ALU_RDY  = 2,
    parameter int LOAD_RDY = 3,
    parameter int SW       = $clog2(DEPTH + 1)
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    issue_valid,
    input  logic                    issue_wen,
    input  logic [REG_W-1:0]        issue_wsel,
    input  logic                    issue_load,
    input  logic [RPORTS*REG_W-1:0] issue_rsel,
    input  logic                    advance,
    input  logic [DEPTH-1:0]        flush_mask,
    output logic                    issue_ready,
    output logic                    stall,
    output logic [RPORTS*SW-1:0]    fwd_sel,
    output logic                    busy,
    output logic [31:0]             stall_cycles
);

`ifdef PIPE_HAZARD_SCOREBOARD_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    // Per-stage entry fields; bit/index k is stage k. Sources live only in stage 1.
    logic [DEPTH:1]             v_q, v_d;
    logic [DEPTH:1]             wen_q, wen_d;
    logic [DEPTH:1]             load_q, load_d;
    logic [DEPTH:1][REG_W-1:0]  wsel_q, wsel_d;
    logic [RPORTS*REG_W-1:0]    rsel_q, rsel_d;
    logic [31:0]                cnt_q, cnt_d;

    logic [RPORTS-1:0]          haz;

    for (genvar p = 0; p < RPORTS; p++) begin : g_port
        logic [REG_W-1:0] rs;
        logic             hit;
        logic             hload;
        logic             ready;
        logic             active;
        logic [SW-1:0]    hk;

        assign rs     = rsel_q[p*REG_W +: REG_W];
        // $0 is hardwired zero, so it never needs a producer.
        assign active = v_q[1] && (rs != '0);

        // Scan oldest to youngest so the youngest matching producer wins.
        always_comb begin
            hit   = 1'b0;
            hk    = '0;
            hload = 1'b0;
            for (int k = DEPTH; k >= 2; k--) begin
                if (v_q[k] && wen_q[k] && (wsel_q[k] == rs)) begin
                    hit   = 1'b1;
                    hk    = SW'(k);
                    hload = load_q[k];
                end
            end
        end

        // Loads produce their value later in the pipe than ALU ops.
        assign ready = hload ? (hk >= SW'(LOAD_RDY)) : (hk >= SW'(ALU_RDY));

        assign haz[p] = active && hit && !(FWD_EN && ready);
        assign fwd_sel[p*SW +: SW] = (active && hit && FWD_EN && ready) ? hk : '0;
    end

    assign stall        = |haz;
    assign issue_ready  = advance && !stall;
    assign busy         = |v_q;
    assign stall_cycles = cnt_q;

    // Next state: shift or stall-with-bubble when advancing, then apply flushes.
    always_comb begin
        v_d    = v_q;
        wen_d  = wen_q;
        load_d = load_q;
        wsel_d = wsel_q;
        rsel_d = rsel_q;
        cnt_d  = cnt_q;
        if (advance) begin
            // Stages 3..DEPTH always shift; the oldest entry drops out.
            for (int k = DEPTH; k >= 3; k--) begin
                v_d[k]    = v_q[k-1];
                wen_d[k]  = wen_q[k-1];
                load_d[k] = load_q[k-1];
                wsel_d[k] = wsel_q[k-1];
            end
            if (stall) begin
                // Stage 1 holds and a bubble enters stage 2.
                v_d[2]    = 1'b0;
                wen_d[2]  = 1'b0;
                load_d[2] = 1'b0;
                wsel_d[2] = '0;
                if (cnt_q != 32'hFFFF_FFFF)
                    cnt_d = cnt_q + 32'd1;
            end else begin
                v_d[2]    = v_q[1];
                wen_d[2]  = wen_q[1];
                load_d[2] = load_q[1];
                wsel_d[2] = wsel_q[1];
                v_d[1]    = issue_valid;
                wen_d[1]  = issue_wen;
                load_d[1] = issue_load;
                wsel_d[1] = issue_wsel;
                rsel_d    = issue_rsel;
            end
        end
        // Flush wins over shift/hold; flushing stage 1 also kills a stall.
        v_d = v_d & ~flush_mask;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            v_q    <= '0;
            wen_q  <= '0;
            load_q <= '0;
            wsel_q <= '0;
            rsel_q <= '0;
            cnt_q  <= '0;
        end else begin
            v_q    <= v_d;
            wen_q  <= wen_d;
            load_q <= load_d;
            wsel_q <= wsel_d;
            rsel_q <= rsel_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Directed bench for pipe_hazard_scoreboard with default parameters
// (DEPTH=3, ALU_RDY=2, LOAD_RDY=3). Expected values differ by build, so
// the forwarding macro selects between two sets of hand-computed values.
module tb_pipe_hazard_scoreboard;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        issue_valid;
    logic        issue_wen;
    logic [4:0]  issue_wsel;
    logic        issue_load;
    logic [9:0]  issue_rsel;
    logic        advance;
    logic [2:0]  flush_mask;
    logic        issue_ready;
    logic        stall;
    logic [3:0]  fwd_sel;
    logic        busy;
    logic [31:0] stall_cycles;

    int n_chk  = 0;
    int n_fail = 0;

    pipe_hazard_scoreboard dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .issue_valid  (issue_valid),
        .issue_wen    (issue_wen),
        .issue_wsel   (issue_wsel),
        .issue_load   (issue_load),
        .issue_rsel   (issue_rsel),
        .advance      (advance),
        .flush_mask   (flush_mask),
        .issue_ready  (issue_ready),
        .stall        (stall),
        .fwd_sel      (fwd_sel),
        .busy         (busy),
        .stall_cycles (stall_cycles)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic vld, input logic wen, input logic [4:0] wsel,
                         input logic ld, input logic [4:0] r0, input logic [4:0] r1);
        issue_valid = vld;
        issue_wen   = wen;
        issue_wsel  = wsel;
        issue_load  = ld;
        issue_rsel  = {r1, r0};
    endtask

    task automatic drain();
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST       = 1'b0;
        advance    = 1'b1;
        flush_mask = '0;
        drive(0, 0, 0, 0, 0, 0);
        #12;
        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_stall", stall, 0);
        chk("rst_fwd", fwd_sel, 0);
        chk("rst_cnt", stall_cycles, 0);
        chk("rst_ready", issue_ready, 1);
        advance = 1'b0;
        #0.5;
        chk("rst_ready_noadv", issue_ready, 0);
        advance = 1'b1;
        #0.5;
        nRST = 1'b1;

        // ALU forwarding: add $3 ; add $6,$3,$1
        drive(1, 1, 3, 0, 1, 2);
        chk("first_issue_ready", issue_ready, 1);
        step();
        chk("first_issue_busy", busy, 1);
        drive(1, 1, 6, 0, 3, 1);
        step();
`ifdef PIPE_HAZARD_SCOREBOARD_FWD_EN
        chk("alu_fwd_sel", fwd_sel, 4'b0010);
        chk("alu_fwd_stall", stall, 0);
        chk("alu_fwd_ready", issue_ready, 1);
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("alu_no_bubble_stall", stall, 0);
        chk("alu_cnt", stall_cycles, 0);
`else
        chk("alu_nofwd_stall1", stall, 1);
        chk("alu_nofwd_fwd", fwd_sel, 0);
        chk("alu_nofwd_ready", issue_ready, 0);
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("alu_nofwd_stall2", stall, 1);
        chk("alu_nofwd_cnt1", stall_cycles, 1);
        step();
        chk("alu_nofwd_resume", stall, 0);
        chk("alu_nofwd_resume_fwd", fwd_sel, 0);
        chk("alu_nofwd_cnt2", stall_cycles, 2);
        chk("alu_nofwd_ready2", issue_ready, 1);
`endif
        drain();
        chk("drain1_busy", busy, 0);

        // Load-use: lw $4 ; sub $2,$1,$4
        drive(1, 1, 4, 1, 1, 0);
        step();
        drive(1, 1, 2, 0, 1, 4);
        step();
        chk("lu_stall", stall, 1);
        chk("lu_ready", issue_ready, 0);
        chk("lu_fwd", fwd_sel, 0);
        drive(0, 0, 0, 0, 0, 0);
        step();
`ifdef PIPE_HAZARD_SCOREBOARD_FWD_EN
        chk("lu_after_stall", stall, 0);
        chk("lu_fwd_sel", fwd_sel, 4'b1100);
        chk("lu_cnt", stall_cycles, 1);
`else
        chk("lu_nofwd_stall2", stall, 1);
        chk("lu_nofwd_cnt3", stall_cycles, 3);
        step();
        chk("lu_nofwd_resume", stall, 0);
        chk("lu_nofwd_fwd", fwd_sel, 0);
        chk("lu_nofwd_cnt4", stall_cycles, 4);
`endif
        drain();

        // Youngest match: two writers of $5, then a $5 consumer
        drive(1, 1, 5, 0, 0, 0);
        step();
        drive(1, 1, 5, 0, 0, 0);
        step();
        drive(1, 0, 0, 0, 5, 0);
        step();
`ifdef PIPE_HAZARD_SCOREBOARD_FWD_EN
        chk("young_fwd", fwd_sel, 4'b0010);
        chk("young_stall", stall, 0);
`else
        chk("young_nofwd_stall", stall, 1);
        chk("young_nofwd_fwd", fwd_sel, 0);
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("young_nofwd_stall2", stall, 1);
        step();
        chk("young_nofwd_resume", stall, 0);
        chk("young_nofwd_cnt", stall_cycles, 6);
`endif
        drain();

        // $0 never forwards or stalls, even against a load to $0
        drive(1, 1, 0, 1, 0, 0);
        step();
        drive(1, 0, 0, 0, 0, 0);
        step();
        chk("r0_stall", stall, 0);
        chk("r0_fwd", fwd_sel, 0);
        chk("r0_ready", issue_ready, 1);
        drain();

        // Freeze during a load-use stall, then flush stage 1
        drive(1, 1, 4, 1, 0, 0);
        step();
        drive(1, 1, 7, 0, 4, 0);
        step();
        chk("frz_stall", stall, 1);
        advance = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        chk("frz_ready", issue_ready, 0);
        repeat (3) step();
        chk("frz_hold_stall", stall, 1);
        chk("frz_hold_busy", busy, 1);
`ifdef PIPE_HAZARD_SCOREBOARD_FWD_EN
        chk("frz_hold_cnt", stall_cycles, 1);
`else
        chk("frz_hold_cnt", stall_cycles, 6);
`endif
        flush_mask = 3'b001;
        step();
        flush_mask = 3'b000;
        chk("flush_stall", stall, 0);
        chk("flush_busy", busy, 1);
        chk("flush_fwd", fwd_sel, 0);
`ifdef PIPE_HAZARD_SCOREBOARD_FWD_EN
        chk("flush_cnt", stall_cycles, 1);
`else
        chk("flush_cnt", stall_cycles, 6);
`endif
        advance = 1'b1;
        #0.5;
        chk("flush_ready", issue_ready, 1);
        drain();
        chk("flush_drain_busy", busy, 0);

        // Reset in the middle of a load-use stall
        drive(1, 1, 4, 1, 0, 0);
        step();
        drive(1, 1, 8, 0, 0, 4);
        step();
        chk("rst2_pre_stall", stall, 1);
        #2;
        nRST = 1'b0;
        #1;
        chk("rst2_busy", busy, 0);
        chk("rst2_stall", stall, 0);
        chk("rst2_fwd", fwd_sel, 0);
        chk("rst2_cnt", stall_cycles, 0);
        #1;
        nRST = 1'b1;
        drive(1, 1, 3, 0, 0, 0);
        chk("rst2_issue_ready", issue_ready, 1);
        step();
        chk("rst2_issue_busy", busy, 1);
        chk("rst2_issue_stall", stall, 0);
        chk("rst2_issue_cnt", stall_cycles, 0);
        drain();
        chk("rst2_drain_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
